// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the gated SR latch sequencer.
package sr_latch_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StSettle,
    StCheck
  } state_e;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Target latch value for a legal opcode; toggle inverts the current feedback.
  function automatic logic op_target(logic [1:0] op, logic q);
    logic t;
    t = 1'b0;
    case (op)
      OP_SET:  t = 1'b1;
      OP_TGL:  t = ~q;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sr_latch_ctrl_cnt.sv
// Loadable 4-bit down-counter with zero flag; times both PULSE and SETTLE phases.
module sr_latch_ctrl_cnt
  import sr_latch_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a gated SR latch: set/clear/toggle requests become ordered S/R/En pulses.
// Define SR_LATCH_CTRL_FB_CHECK_EN to compare Q/Qn feedback against the target in CHECK.
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Req,
  input  logic [1:0] i_Op,
  input  logic       i_Q,
  input  logic       i_Qn,
  output logic       o_En,
  output logic       o_S,
  output logic       o_R,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Err
);

  localparam logic [CNT_W-1:0] PulseLoad  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);

  state_e state_q, state_d;
  logic   target_q, target_d;
  logic   en_q, en_d;
  logic   s_q, s_d;
  logic   r_q, r_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             fb_err;
  logic             drive_phase;

`ifdef SR_LATCH_CTRL_FB_CHECK_EN
  assign fb_err = (i_Q != target_q) | (i_Qn != ~target_q);
`else
  logic unused_fb;
  assign unused_fb = i_Qn;
  assign fb_err    = 1'b0;
`endif

  sr_latch_ctrl_cnt u_cnt (
    .clk_i      (i_Clk),
    .rst_i      (i_Rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_Req) begin
          if (i_Op == OP_ILL) begin
            state_d = StCheck;
            err_d   = 1'b1;
          end else begin
            target_d = op_target(i_Op, i_Q);
            state_d  = StSetup;
          end
        end
      end
      StSetup: begin
        state_d      = StPulse;
        cnt_load     = 1'b1;
        cnt_load_val = PulseLoad;
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d = StHold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHold: begin
        state_d      = StSettle;
        cnt_load     = 1'b1;
        cnt_load_val = SettleLoad;
      end
      StSettle: begin
        // Feedback is sampled at the edge that ends the last SETTLE cycle.
        if (cnt_zero) begin
          state_d = StCheck;
          err_d   = fb_err;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    drive_phase = (state_d == StSetup) || (state_d == StPulse) || (state_d == StHold);
    en_d        = (state_d == StPulse);
    s_d         = drive_phase & target_d;
    r_d         = drive_phase & ~target_d;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StCheck);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
      en_q     <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      en_q     <= en_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_En   = en_q;
  assign o_S    = s_q;
  assign o_R    = r_q;
  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_Err  = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl with a behavioural gated SR latch on the feedback path.
module tb_sr_latch_ctrl;

  localparam int unsigned P = 2;
  localparam int unsigned S = 1;
  localparam int unsigned OpLen = 3 + P + S;

`ifdef SR_LATCH_CTRL_FB_CHECK_EN
  localparam bit FbChk = 1'b1;
`else
  localparam bit FbChk = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req;
  logic [1:0] op;
  logic       fb_q, fb_qn;
  logic       en, s_o, r_o, busy, done, err;

  logic lq = 1'b0;
  logic stuck = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic        q;
  } exp_t;

  exp_t exp_q[$];

  int unsigned chk_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned edge_cnt = 0;
  bit          hold_mode = 1'b0;
  int          last_acc = -1;

  sr_latch_ctrl #(
    .PULSE_CYC  (P),
    .SETTLE_CYC (S)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .i_Req  (req),
    .i_Op   (op),
    .i_Q    (fb_q),
    .i_Qn   (fb_qn),
    .o_En   (en),
    .o_S    (s_o),
    .o_R    (r_o),
    .o_Busy (busy),
    .o_Done (done),
    .o_Err  (err)
  );

  // Behavioural gated SR latch.
  always @(en or s_o or r_o) begin
    if (en) begin
      if (s_o && !r_o) lq = 1'b1;
      else if (r_o && !s_o) lq = 1'b0;
    end
  end

  assign fb_q  = stuck ? 1'b0 : lq;
  assign fb_qn = ~fb_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard producer: a request is accepted at an edge where the DUT is idle.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (req && !busy) begin
      exp_t e;
      if (op == 2'b11) begin
        e.cyc = edge_cnt + 1;
        e.err = 1'b1;
        e.q   = lq;
      end else begin
        e.cyc = edge_cnt + OpLen;
        e.err = FbChk && stuck;
        e.q   = (op == 2'b01) ? 1'b1 : (op == 2'b00) ? 1'b0 : ~fb_q;
      end
      exp_q.push_back(e);
      if (hold_mode) begin
        if (last_acc >= 0) check_eq("acc_gap", edge_cnt - last_acc, OpLen + 1);
        last_acc = int'(edge_cnt);
      end
    end
    edge_cnt = edge_cnt + 1;
  end

  // Scoreboard consumer and per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("s_and_r", {31'd0, s_o & r_o}, 0);
      if (en) check_eq("en_drive", {31'd0, s_o ^ r_o}, 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("done_cycle", edge_cnt, e.cyc);
          check_eq("done_err", {31'd0, err}, {31'd0, e.err});
          check_eq("latch_q", {31'd0, lq}, {31'd0, e.q});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_en"}, {31'd0, en}, 0);
    check_eq({pfx, "_s"}, {31'd0, s_o}, 0);
    check_eq({pfx, "_r"}, {31'd0, r_o}, 0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 0);
    check_eq({pfx, "_done"}, {31'd0, done}, 0);
    check_eq({pfx, "_err"}, {31'd0, err}, 0);
  endtask

  // Issue one request and check the full phase table against the cycle index.
  task automatic run_op(input logic [1:0] o);
    logic tgt;
    logic ill;
    ill = (o == 2'b11);
    tgt = (o == 2'b01) ? 1'b1 : (o == 2'b00) ? 1'b0 : ~fb_q;
    op  = o;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 1; k <= int'(OpLen) + 1; k++) begin
      if (ill) begin
        check_eq("ill_en", {31'd0, en}, 0);
        check_eq("ill_sr", {30'd0, s_o, r_o}, 0);
        check_eq("ill_done", {31'd0, done}, (k == 1) ? 1 : 0);
        check_eq("ill_err", {31'd0, err}, (k == 1) ? 1 : 0);
        check_eq("ill_busy", {31'd0, busy}, (k == 1) ? 1 : 0);
      end else begin
        logic drv;
        drv = (k >= 1) && (k <= int'(P) + 2);
        check_eq("ph_s", {31'd0, s_o}, {31'd0, drv & tgt});
        check_eq("ph_r", {31'd0, r_o}, {31'd0, drv & ~tgt});
        check_eq("ph_en", {31'd0, en}, ((k >= 2) && (k <= int'(P) + 1)) ? 1 : 0);
        check_eq("ph_busy", {31'd0, busy}, (k <= int'(OpLen)) ? 1 : 0);
        check_eq("ph_done", {31'd0, done}, (k == int'(OpLen)) ? 1 : 0);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    op  = 2'b00;
    tick();
    tick();
    check_idle_outputs("rst");
    rst = 1'b0;
    tick();

    run_op(2'b01);                       // set
    check_eq("q_after_set", {31'd0, lq}, 1);
    run_op(2'b10);                       // toggle 1 -> 0
    check_eq("q_after_tgl", {31'd0, lq}, 0);
    run_op(2'b11);                       // illegal
    check_eq("q_after_ill", {31'd0, lq}, 0);
    run_op(2'b00);                       // clear

    stuck = 1'b1;                        // feedback stuck low during a set
    run_op(2'b01);
    stuck = 1'b0;
    tick();

    hold_mode = 1'b1;                    // request held high continuously
    last_acc  = -1;
    op  = 2'b10;
    req = 1'b1;
    repeat (30) tick();
    req = 1'b0;
    hold_mode = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check_eq("hold_idle", {31'd0, busy}, 0);
    tick();

    op  = 2'b01;                         // reset in the middle of PULSE
    req = 1'b1;
    tick();                              // cycle N+1
    req = 1'b0;
    tick();                              // cycle N+2
    tick();                              // cycle N+3
    check_eq("mid_en", {31'd0, en}, 1);
    rst = 1'b1;
    tick();                              // cycle N+4
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    tick();
    run_op(2'b00);
    check_eq("q_after_rst_clr", {31'd0, lq}, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check_eq("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous sequencer that drives the gated SR latch: it converts single-cycle set/clear/toggle requests into correctly ordered S/R and enable pulses with programmable widths. It also checks the latch's Q/Qn feedback after settling. It sits between clocked lab logic and the asynchronous gated latch, giving the latch a request/done handshake and keeping S and R from both being asserted.

## Interface
- PULSE_CYC, 2: cycles o_En is held high per operation; legal range 1..15.
- SETTLE_CYC, 1: cycles waited after enable drops before feedback is sampled; legal range 1..15.
- i_Clk  input  1  clock; all logic on the rising edge.
- i_Rst  input  1  reset; one clock, reset is synchronous and active-high.
- i_Req  input  1  operation request; sampled only when o_Busy=0.
- i_Op  input  2  opcode: 00 clear, 01 set, 10 toggle, 11 illegal.
- i_Q  input  1  latch Q feedback.
- i_Qn  input  1  latch Qn feedback.
- o_En  output  1  latch enable.
- o_S  output  1  latch set input.
- o_R  output  1  latch reset input.
- o_Busy  output  1  operation in progress.
- o_Done  output  1  one-cycle completion strobe.
- o_Err  output  1  error flag; valid only when o_Done=1.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- States: IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK.
- IDLE, with i_Req=1:
  - Latch the target value: set→1, clear→0, toggle→~i_Q sampled at that edge.
  - Go to SETUP, and set o_Busy=1.
- IDLE, with i_Req=1 and i_Op=11: go directly to CHECK with forced error; no latch pulse is issued.
- SETUP (1 cycle):
  - Drive o_S=target and o_R=~target.
  - Hold o_En=0.
- PULSE (PULSE_CYC cycles): o_En=1, with o_S/o_R unchanged.
- HOLD (1 cycle): o_En=0, with o_S/o_R unchanged. This guarantees data hold past the enable drop.
- SETTLE (SETTLE_CYC cycles): o_S=o_R=0, o_En=0.
- CHECK (1 cycle):
  - o_Done=1.
  - o_Err=1 if the op was illegal, or if the feedback does not match (i_Q≠target or i_Qn≠~target).
  - Go to IDLE, with o_Busy=0 in the next cycle.
- Invariants:
  - o_S&o_R is never 1.
  - o_En=1 only in PULSE.
  - o_S/o_R never change while o_En=1.
- i_Req while o_Busy=1 is ignored; there is no queueing.
- Reset mid-operation: all outputs are 0 the cycle after the reset edge and the FSM returns to IDLE. The latch keeps whatever value it had.
- The shared cycle counter loads PULSE_CYC-1 or SETTLE_CYC-1 on state entry and decrements to 0. It is 4 bits wide.

## Timing
- Request accepted at edge N. Output phases by cycle:
  - N+1: SETUP.
  - N+2 … N+1+P: PULSE.
  - N+2+P: HOLD.
  - N+3+P … N+2+P+S: SETTLE.
  - N+3+P+S: CHECK.
- Defaults (P=2, S=1): o_Done is high in cycle N+6. The next request is accepted at the edge ending cycle N+7 (first IDLE cycle), so throughput is one operation per 7 cycles.
- Illegal op: o_Done=o_Err=1 in cycle N+1.
- Feedback is sampled at the edge that ends the last SETTLE cycle.

## Configuration
- SR_LATCH_CTRL_FB_CHECK_EN:
  - Defined: CHECK compares i_Q/i_Qn as described above.
  - Undefined: feedback is not compared and o_Err=1 only for illegal ops. i_Q is still used to compute the toggle target. All latencies are unchanged.

## Structure
- Package sr_latch_ctrl_pkg holds:
  - The state enum (6 states).
  - The opcode constants OP_CLR, OP_SET, OP_TGL, OP_ILL.
  - The counter width constant CNT_W=4.
- One sub-module, sr_latch_ctrl_cnt: a loadable down-counter with a zero flag, used for both the PULSE and SETTLE phases.
- The test bench instantiates sr_latch_ctrl together with a behavioural gated SR latch model.

## Test plan
- Reset, then set (i_Op=01) with default parameters:
  - o_S=1, o_R=0 from N+1 to N+4.
  - o_En=1 during N+2 and N+3.
  - o_Done=1, o_Err=0 at N+6, and the latch Q=1.
- With Q=1, toggle (i_Op=10): target 0, o_R=1; Q=0 at CHECK; o_Err=0.
- Illegal op (i_Op=11): o_Done=o_Err=1 at N+1; o_En, o_S and o_R stay 0.
- Feedback stuck at i_Q=0 while doing a set:
  - With the macro: o_Err=1 at CHECK.
  - Without the macro: o_Err=0.
- i_Req held high continuously: operations are accepted every 7 cycles only; o_S&o_R=0 is checked every cycle.
- Reset asserted in cycle N+3 (mid-PULSE): the next cycle shows all outputs 0 and the FSM in IDLE; a new request afterwards completes normally.
